// File: rtl/mca_histogram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mca_histogram                                               |
// | Brief  : MCA accumulation stage. Bins peak amplitudes into a         |
// |          2^ADDR_W x CNT_W histogram RAM through a 3-stage            |
// |          read-modify-write pipeline with write forwarding, and       |
// |          offers an independent registered read port for readout.     |
// |          Handles clear sweep, freeze and drop/total statistics.      |
// | Option : `define MCA_SAT_FLAG_EN to enable the sticky sat_flag       |
// |          output. Without it sat_flag is tied low.                    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mca_histogram #(
  parameter int ADC_W  = 14,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              peak_valid,
  input  logic [ADC_W-1:0]  peak_value,
  input  logic              freeze,
  input  logic              clear,
  output logic              busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic [31:0]       total_cnt,
  output logic [15:0]       drop_cnt,
  output logic              sat_flag
);

  // ------------------------------------------------------------------
  // Constants
  // ------------------------------------------------------------------
  localparam int                c_DEPTH     = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;
  localparam logic [ADDR_W-1:0] c_ADDR_LAST = '1;
  localparam logic [15:0]       c_DROP_MAX  = 16'hFFFF;

  localparam logic [1:0] c_ST_RUN   = 2'd0;
  localparam logic [1:0] c_ST_DRAIN = 2'd1;
  localparam logic [1:0] c_ST_CLEAR = 2'd2;

  // ------------------------------------------------------------------
  // Declarations
  // ------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_drain_cnt;
  logic              r_clr_first;   // first cycle of a (re)started sweep
  logic              w_run;
  logic              w_clr_we;

  logic [ADDR_W-1:0] w_bin;
  logic              w_accept;
  logic              w_drop;
  logic              w_unused_peak;

  logic [CNT_W-1:0]  r_mem [c_DEPTH];
  logic [CNT_W-1:0]  r_ram_q;       // port A read data for the S1 event

  logic              r_s1_valid;
  logic [ADDR_W-1:0] r_s1_bin;
  logic [CNT_W-1:0]  w_s1_q;
  logic [CNT_W-1:0]  w_s1_new;

  logic              r_s2_valid;
  logic [ADDR_W-1:0] r_s2_bin;
  logic [CNT_W-1:0]  r_s2_data;

  // Copy of the write that landed on the previous edge; the port A read
  // issued on that same edge returned the pre-write value.
  logic              r_s3_valid;
  logic [ADDR_W-1:0] r_s3_bin;
  logic [CNT_W-1:0]  r_s3_data;

  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [CNT_W-1:0]  w_wr_data;

  logic [CNT_W-1:0]  r_rd_data;
  logic [31:0]       r_total;
  logic [15:0]       r_drop;

  // ------------------------------------------------------------------
  // Event classification
  // ------------------------------------------------------------------
  assign w_bin    = peak_value[ADC_W-1 -: ADDR_W];
  assign w_accept = peak_valid & ~freeze & w_run;
  assign w_drop   = peak_valid & (freeze | ~w_run);

  // Low-order amplitude bits are below bin resolution.
  assign w_unused_peak = &{1'b0, peak_value};

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------

  // State register; reset starts a clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: RUN -> DRAIN (2 cycles) -> CLEAR (full sweep) -> RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN: begin
        if (clear) begin
          w_state_nxt = c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        // clear is deliberately ignored here; the sweep follows anyway
        if (r_drain_cnt) begin
          w_state_nxt = c_ST_CLEAR;
        end
      end
      c_ST_CLEAR: begin
        if (!clear && (r_clr_addr == c_ADDR_LAST)) begin
          w_state_nxt = c_ST_RUN;
        end
      end
      default: begin
        w_state_nxt = c_ST_CLEAR;
      end
    endcase
  end

  // State-decoded outputs: busy outside RUN, clear writes during CLEAR.
  always_comb begin
    w_run    = 1'b0;
    w_clr_we = 1'b0;
    busy     = 1'b1;
    case (r_state)
      c_ST_RUN: begin
        w_run = 1'b1;
        busy  = 1'b0;
      end
      c_ST_CLEAR: begin
        w_clr_we = 1'b1;
      end
      default: begin
        w_run    = 1'b0;
        w_clr_we = 1'b0;
      end
    endcase
  end

  // Sweep address, drain timer and first-sweep-cycle marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_addr  <= '0;
      r_drain_cnt <= 1'b0;
      r_clr_first <= 1'b1;
    end else begin
      // a clear strobe during the sweep restarts it from address 0
      r_clr_addr  <= ((r_state == c_ST_CLEAR) && !clear) ? r_clr_addr + 1'b1 : '0;
      r_drain_cnt <= (r_state == c_ST_DRAIN) ? ~r_drain_cnt : 1'b0;
      r_clr_first <= (w_state_nxt == c_ST_CLEAR) &&
                     ((r_state != c_ST_CLEAR) || clear);
    end
  end

  // ------------------------------------------------------------------
  // Increment pipeline (port A)
  // ------------------------------------------------------------------

  // S0: port A read of the incoming event's bin.
  always_ff @(posedge clk) begin
    r_ram_q <= r_mem[w_bin];
  end

  // S0 -> S1: capture accepted event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_bin   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_bin   <= w_bin;
    end
  end

  // S1: pick the freshest count for the bin and compute the saturating increment.
  always_comb begin
    w_s1_q = r_ram_q;
    if (r_s2_valid && (r_s2_bin == r_s1_bin)) begin
      // write still pending this cycle (back-to-back same bin)
      w_s1_q = r_s2_data;
    end else if (r_s3_valid && (r_s3_bin == r_s1_bin)) begin
      // write landed on the same edge as our read (every-other cycle)
      w_s1_q = r_s3_data;
    end
    w_s1_new = (w_s1_q == c_CNT_MAX) ? c_CNT_MAX : w_s1_q + 1'b1;
  end

  // S1 -> S2 -> S3 pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_bin   <= '0;
      r_s2_data  <= '0;
      r_s3_valid <= 1'b0;
      r_s3_bin   <= '0;
      r_s3_data  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_bin   <= r_s1_bin;
      r_s2_data  <= w_s1_new;
      r_s3_valid <= r_s2_valid;
      r_s3_bin   <= r_s2_bin;
      r_s3_data  <= r_s2_data;
    end
  end

  // Port A write mux: sweep zeroes have priority; never both active at once.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_s2_bin;
    w_wr_data = r_s2_data;
    if (!rst) begin
      if (w_clr_we) begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_clr_addr;
        w_wr_data = '0;
      end else if (r_s2_valid) begin
        w_wr_en = 1'b1;
      end
    end
  end

  // Port A write into the histogram RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Port B: registered readout, old data on a same-address port A write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

  // ------------------------------------------------------------------
  // Statistics
  // ------------------------------------------------------------------

  // Accept/drop counters; zeroed in the first sweep cycle, which also
  // swallows any event arriving in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_total <= '0;
      r_drop  <= '0;
    end else if (r_clr_first) begin
      r_total <= '0;
      r_drop  <= '0;
    end else begin
      if (w_accept) begin
        r_total <= r_total + 32'd1;
      end
      if (w_drop && (r_drop != c_DROP_MAX)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign total_cnt = r_total;
  assign drop_cnt  = r_drop;

`ifdef MCA_SAT_FLAG_EN
  logic r_sat;

  // Sticky flag: set when a pipeline write stores the maximum count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (r_clr_first) begin
      r_sat <= 1'b0;
    end else if (r_s2_valid && (r_s2_data == c_CNT_MAX)) begin
      r_sat <= 1'b1;
    end
  end

  assign sat_flag = r_sat;
`else
  assign sat_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mca_histogram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_mca_histogram                                            |
// | Brief  : self-checking bench for mca_histogram with a per-bin count  |
// |          model, event statistics model and randomized traffic.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_mca_histogram;

  localparam int ADC_W   = 14;
  localparam int ADDR_W  = 10;
  localparam int CNT_W   = 16;
  localparam int NBINS   = 1 << ADDR_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int SHIFT   = ADC_W - ADDR_W;
`ifdef MCA_SAT_FLAG_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic              clk        = 1'b0;
  logic              rst        = 1'b1;
  logic              peak_valid = 1'b0;
  logic [ADC_W-1:0]  peak_value = '0;
  logic              freeze     = 1'b0;
  logic              clear      = 1'b0;
  logic              busy;
  logic [ADDR_W-1:0] rd_addr    = '0;
  logic [CNT_W-1:0]  rd_data;
  logic [31:0]       total_cnt;
  logic [15:0]       drop_cnt;
  logic              sat_flag;

  always #5 clk = ~clk;

  mca_histogram #(.ADC_W(ADC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .peak_valid (peak_valid),
    .peak_value (peak_value),
    .freeze     (freeze),
    .clear      (clear),
    .busy       (busy),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .total_cnt  (total_cnt),
    .drop_cnt   (drop_cnt),
    .sat_flag   (sat_flag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: counts per bin plus event statistics
  int          model_bin [NBINS];
  logic [31:0] model_total;
  int          model_drop;
  bit          model_sat;
  int          rd_bins [NBINS];

  function automatic void model_reset();
    for (int i = 0; i < NBINS; i++) model_bin[i] = 0;
    model_total = '0;
    model_drop  = 0;
    model_sat   = 1'b0;
  endfunction

  // one event: either lands in its bin (saturating) or counts as a drop
  function automatic void model_event(input logic [ADC_W-1:0] v, input bit dropped);
    int b;
    b = int'(v) >> SHIFT;
    if (dropped) begin
      if (model_drop < 65535) model_drop++;
    end else begin
      model_total = model_total + 32'd1;
      if (model_bin[b] < CNT_MAX) begin
        model_bin[b]++;
        if (model_bin[b] == CNT_MAX && SAT_EN) model_sat = 1'b1;
      end
    end
  endfunction

  function automatic logic [ADC_W-1:0] value_for_bin(input int b);
    return ADC_W'((b << SHIFT) | int'($urandom_range(0, (1 << SHIFT) - 1)));
  endfunction

  // pipelined sweep of all bins through the read port
  task automatic read_all();
    for (int i = 0; i <= NBINS; i++) begin
      @(negedge clk);
      if (i > 0) rd_bins[i-1] = int'(rd_data);
      if (i < NBINS) rd_addr = ADDR_W'(i);
    end
  endtask

  task automatic read_bin(input int a, output int d);
    @(negedge clk);
    rd_addr = ADDR_W'(a);
    @(negedge clk);
    d = int'(rd_data);
  endtask

  task automatic test_reset();
    int cnt, bad, first;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if (total_cnt !== 32'd0) $display("FAIL reset_total: got %0d want 0", total_cnt); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else n_pass++;
    n_checks++; if (sat_flag !== 1'b0) $display("FAIL reset_sat: got %b want 0", sat_flag); else n_pass++;
    n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %0d want 0", rd_data); else n_pass++;
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++; if (cnt != NBINS) $display("FAIL reset_busy_len: got %0d want %0d", cnt, NBINS); else n_pass++;
    read_all();
    bad = 0; first = -1;
    for (int i = 0; i < NBINS; i++) if (rd_bins[i] != 0) begin bad++; if (first < 0) first = i; end
    n_checks++;
    if (bad != 0) $display("FAIL reset_sweep: %0d bins nonzero, bin %0d got %0d want 0", bad, first, rd_bins[first]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    rd_addr = ADDR_W'(NBINS - 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      peak_valid = 1'b1; peak_value = 14'h3FFF;
      model_event(peak_value, 1'b0);
    end
    @(negedge clk); peak_valid = 1'b0;
    // last accept was 4 edges ago: count must already be on the read port
    repeat (3) @(negedge clk);
    n_checks++; if (int'(rd_data) != model_bin[NBINS-1]) $display("FAIL b2b_bin1023: got %0d want %0d", rd_data, model_bin[NBINS-1]); else n_pass++;
    n_checks++; if (total_cnt !== model_total) $display("FAIL b2b_total: got %0d want %0d", total_cnt, model_total); else n_pass++;
    n_checks++; if (int'(drop_cnt) != model_drop) $display("FAIL b2b_drop: got %0d want %0d", drop_cnt, model_drop); else n_pass++;
  endtask

  task automatic test_alternate();
    int d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      peak_valid = 1'b1;
      peak_value = (i % 2 == 0) ? 14'h0040 : 14'h0050;   // bins 4 and 5
      model_event(peak_value, 1'b0);
    end
    @(negedge clk); peak_valid = 1'b0;
    repeat (4) @(negedge clk);
    read_bin(4, d);
    n_checks++; if (d != model_bin[4]) $display("FAIL alt_bin4: got %0d want %0d", d, model_bin[4]); else n_pass++;
    read_bin(5, d);
    n_checks++; if (d != model_bin[5]) $display("FAIL alt_bin5: got %0d want %0d", d, model_bin[5]); else n_pass++;
    n_checks++; if (total_cnt !== model_total) $display("FAIL alt_total: got %0d want %0d", total_cnt, model_total); else n_pass++;
  endtask

  task automatic test_freeze();
    int d, bad, first;
    freeze = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      peak_valid = 1'b1; peak_value = 14'($urandom);
      model_event(peak_value, 1'b1);
    end
    @(negedge clk); peak_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (int'(drop_cnt) != model_drop) $display("FAIL frz_drop: got %0d want %0d", drop_cnt, model_drop); else n_pass++;
    freeze = 1'b0;
    @(negedge clk);
    peak_valid = 1'b1; peak_value = 14'h0020;   // bin 2
    model_event(peak_value, 1'b0);
    @(negedge clk); peak_valid = 1'b0;
    repeat (4) @(negedge clk);
    read_bin(2, d);
    n_checks++; if (d != model_bin[2]) $display("FAIL frz_bin2: got %0d want %0d", d, model_bin[2]); else n_pass++;
    read_all();
    bad = 0; first = -1;
    for (int i = 0; i < NBINS; i++) if (rd_bins[i] != model_bin[i]) begin bad++; if (first < 0) first = i; end
    n_checks++;
    if (bad != 0) $display("FAIL frz_sweep: %0d bins differ, bin %0d got %0d want %0d", bad, first, rd_bins[first], model_bin[first]);
    else n_pass++;
    n_checks++; if (total_cnt !== model_total) $display("FAIL frz_total: got %0d want %0d", total_cnt, model_total); else n_pass++;
  endtask

  task automatic test_random();
    int hot [4] = '{6, 7, 8, 1023};
    int b, bad, first;
    bit v, f;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 9) < 2);
      b = ($urandom_range(0, 4) == 4) ? int'($urandom_range(0, NBINS - 1)) : hot[$urandom_range(0, 3)];
      peak_valid = v; freeze = f; peak_value = value_for_bin(b);
      if (v) model_event(peak_value, f);
    end
    @(negedge clk); peak_valid = 1'b0; freeze = 1'b0;
    repeat (4) @(negedge clk);
    read_all();
    bad = 0; first = -1;
    for (int i = 0; i < NBINS; i++) if (rd_bins[i] != model_bin[i]) begin bad++; if (first < 0) first = i; end
    n_checks++;
    if (bad != 0) $display("FAIL rnd_sweep: %0d bins differ, bin %0d got %0d want %0d", bad, first, rd_bins[first], model_bin[first]);
    else n_pass++;
    n_checks++; if (total_cnt !== model_total) $display("FAIL rnd_total: got %0d want %0d", total_cnt, model_total); else n_pass++;
    n_checks++; if (int'(drop_cnt) != model_drop) $display("FAIL rnd_drop: got %0d want %0d", drop_cnt, model_drop); else n_pass++;
  endtask

  task automatic test_saturate();
    int n, d;
    n = (CNT_MAX - 1) - model_bin[3];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      peak_valid = 1'b1; peak_value = value_for_bin(3);
      model_event(peak_value, 1'b0);
    end
    @(negedge clk); peak_valid = 1'b0;
    repeat (4) @(negedge clk);
    read_bin(3, d);
    n_checks++; if (d != CNT_MAX - 1) $display("FAIL sat_pre_bin3: got %0d want %0d", d, CNT_MAX - 1); else n_pass++;
    n_checks++; if (sat_flag !== 1'b0) $display("FAIL sat_pre_flag: got %b want 0", sat_flag); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      peak_valid = 1'b1; peak_value = value_for_bin(3);
      model_event(peak_value, 1'b0);
    end
    @(negedge clk); peak_valid = 1'b0;
    repeat (4) @(negedge clk);
    read_bin(3, d);
    n_checks++; if (d != model_bin[3]) $display("FAIL sat_bin3: got %0d want %0d", d, model_bin[3]); else n_pass++;
    n_checks++; if (sat_flag !== model_sat) $display("FAIL sat_flag: got %b want %b", sat_flag, model_sat); else n_pass++;
    n_checks++; if (total_cnt !== model_total) $display("FAIL sat_total: got %0d want %0d", total_cnt, model_total); else n_pass++;
  endtask

  // clear while traffic continues: accept in RUN, counted drops in DRAIN,
  // uncounted drop in the first sweep cycle
  task automatic test_clear();
    int busy_cnt, bad, first;
    @(negedge clk);
    clear = 1'b1; peak_valid = 1'b1; peak_value = 14'($urandom);
    model_event(peak_value, 1'b0);
    busy_cnt = 0;
    for (int i = 1; i < 3000; i++) begin
      @(negedge clk);
      clear = 1'b0;
      if (i == 3) begin
        n_checks++; if (total_cnt !== model_total) $display("FAIL clr_total_before: got %0d want %0d", total_cnt, model_total); else n_pass++;
        n_checks++; if (int'(drop_cnt) != model_drop) $display("FAIL clr_drop_before: got %0d want %0d", drop_cnt, model_drop); else n_pass++;
      end
      if (i == 4) begin
        model_reset();
        n_checks++; if (total_cnt !== 32'd0) $display("FAIL clr_total_zero: got %0d want 0", total_cnt); else n_pass++;
        n_checks++; if (drop_cnt !== 16'd0) $display("FAIL clr_drop_zero: got %0d want 0", drop_cnt); else n_pass++;
      end
      if (i <= 3) begin
        peak_valid = 1'b1; peak_value = 14'($urandom);
        if (i < 3) model_event(peak_value, 1'b1);
      end else begin
        peak_valid = 1'b0;
      end
      if (busy === 1'b1) busy_cnt++;
      else break;
    end
    n_checks++; if (busy_cnt != NBINS + 2) $display("FAIL clr_busy_len: got %0d want %0d", busy_cnt, NBINS + 2); else n_pass++;
    read_all();
    bad = 0; first = -1;
    for (int i = 0; i < NBINS; i++) if (rd_bins[i] != 0) begin bad++; if (first < 0) first = i; end
    n_checks++;
    if (bad != 0) $display("FAIL clr_sweep: %0d bins nonzero, bin %0d got %0d want 0", bad, first, rd_bins[first]);
    else n_pass++;
    n_checks++; if (sat_flag !== 1'b0) $display("FAIL clr_sat: got %b want 0", sat_flag); else n_pass++;
    n_checks++; if (total_cnt !== 32'd0 || drop_cnt !== 16'd0) $display("FAIL clr_stats: got total %0d drop %0d want 0 0", total_cnt, drop_cnt); else n_pass++;
  endtask

  // clear in DRAIN is ignored; clear inside the sweep restarts it at addr 0
  task automatic test_clear_restart();
    int busy_cnt;
    @(negedge clk);
    clear = 1'b1;
    busy_cnt = 0;
    for (int i = 1; i < 3000; i++) begin
      @(negedge clk);
      clear = (i == 1) || (i == 53);
      peak_valid = (i == 5);
      peak_value = 14'h0100;
      if (i == 10) begin
        n_checks++; if (drop_cnt !== 16'd1) $display("FAIL rst_clr_mid_drop: got %0d want 1", drop_cnt); else n_pass++;
      end
      if (busy === 1'b1) busy_cnt++;
      else break;
    end
    n_checks++; if (busy_cnt != 53 + NBINS) $display("FAIL rst_clr_busy_len: got %0d want %0d", busy_cnt, 53 + NBINS); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL rst_clr_drop: got %0d want 0", drop_cnt); else n_pass++;
    n_checks++; if (total_cnt !== 32'd0) $display("FAIL rst_clr_total: got %0d want 0", total_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alternate();
    test_freeze();
    test_random();
    test_saturate();
    test_clear();
    test_clear_restart();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
